uart_apb_master: RTL

Converts 56-bit request frames from the UART receive path into single APB transfers and returns a 56-bit response frame to the UART transmit path. It sits between the UART receiver output (`pdata_out`/`data_vld_rx`) and the transmitter response input (`pres`/`data_vld_tx_res`). It back-pressures the receiver through `full_to_rx`. One transaction is in flight at a time.

---
 rtl/uart_apb_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_apb_master.sv
// Bridges 56-bit UART request frames to single APB transfers and returns 56-bit response frames.
// Define UART_APB_TIMEOUT_EN to build the ACCESS-phase timeout counter and response timeout flag.
module uart_apb_master #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [55:0] req_data,
    input  logic        req_vld,
    output logic        req_full,
    output logic [55:0] resp_data,
    output logic        resp_vld,
    input  logic        resp_ren,
    output logic [15:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic [7:0]  drop_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [2:0]  tag_q, tag_d;
    logic        req_full_q, req_full_d;
    logic        resp_vld_q, resp_vld_d;
    logic [55:0] resp_data_q, resp_data_d;
    logic [7:0]  drop_count_q, drop_count_d;

`ifdef UART_APB_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`else
    logic [7:0]  unused_timeout_cyc;
    assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        pwrite_d     = pwrite_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        tag_d        = tag_q;
        resp_vld_d   = resp_vld_q;
        resp_data_d  = resp_data_q;
        drop_count_d = drop_count_q;
`ifdef UART_APB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        // Only one transaction in flight; anything arriving while busy is counted and discarded.
        if (req_vld && (state_q != ST_IDLE) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    pwrite_d = req_data[55];
                    pstrb_d  = req_data[55] ? req_data[54:51] : 4'h0;
                    tag_d    = req_data[50:48];
                    paddr_d  = req_data[47:32];
                    pwdata_d = req_data[31:0];
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef UART_APB_TIMEOUT_EN
                cnt_d     = 8'd1;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    resp_vld_d  = 1'b1;
                    resp_data_d = {pwrite_q, pslverr, 1'b0, 2'b00, tag_q, paddr_q,
                                   pwrite_q ? pwdata_q : prdata};
                    state_d     = ST_RESP;
                end
`ifdef UART_APB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYC)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    resp_vld_d  = 1'b1;
                    resp_data_d = {pwrite_q, 1'b0, 1'b1, 2'b00, tag_q, paddr_q, 32'h0};
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ren) begin
                    resp_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_full_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            paddr_q      <= 16'h0;
            pwdata_q     <= 32'h0;
            pstrb_q      <= 4'h0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            tag_q        <= 3'h0;
            req_full_q   <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_data_q  <= 56'h0;
            drop_count_q <= 8'h0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            tag_q        <= tag_d;
            req_full_q   <= req_full_d;
            resp_vld_q   <= resp_vld_d;
            resp_data_q  <= resp_data_d;
            drop_count_q <= drop_count_d;
        end
    end

`ifdef UART_APB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_full   = req_full_q;
    assign resp_data  = resp_data_q;
    assign resp_vld   = resp_vld_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign pwrite     = pwrite_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign drop_count = drop_count_q;

endmodule
